// File: rtl/seg7_bcd_display_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg7_pkg : shared types and constants for the BCD seven-segment display |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Raw {g,f,e,d,c,b,a} patterns for decimal digits 0..9
  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_bcd_display_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg7_bcd_display_if : start/busy/done handshake and display outputs    |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
interface seg7_bcd_display_if #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 2
);
  logic                  start;
  logic [IN_W-1:0]       bin_in;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   seg;

  modport master (output start, bin_in, input  busy, done, overflow, seg);
  modport slave  (input  start, bin_in, output busy, done, overflow, seg);
endinterface
`default_nettype wire

// File: rtl/seg7_bcd_display_encode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg7_encode : one BCD digit to raw active-high segments                |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash wins over blanking; out-of-range nibbles decode to blank
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank && (digit <= 4'd9)) begin
      seg = SEG_DIGITS[digit];
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_bcd_display.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seg7_bcd_display : serial double-dabble binary to BCD converter that   |
// |                    drives DIGITS seven-segment digits                  |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module seg7_bcd_display
  import seg7_pkg::*;
#(
  parameter int IN_W           = 7,
  parameter int DIGITS         = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int BLANK_LZ       = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_bcd_display_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SEG_W = 7 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);

  localparam logic [31:0]      MAX_DEC    = 32'(pow10(DIGITS) - 1);
  localparam logic [31:0]      MAX_BIN    = 32'((1 << IN_W) - 1);
  localparam bit               OVF_EN     = (MAX_BIN > MAX_DEC);
  localparam logic [SEG_W-1:0] SEG_INV    = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

  state_t            r_state;
  logic [IN_W-1:0]   r_shreg;
  logic [BCD_W-1:0]  r_bcd;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf_n;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic [SEG_W-1:0]  r_seg;

  logic              w_ovf_in;
  logic [BCD_W-1:0]  w_bcd_adj;
  logic [DIGITS-1:0] w_blank;
  logic [SEG_W-1:0]  w_seg_raw;

  assign w_ovf_in = OVF_EN && (32'(bus.bin_in) > MAX_DEC);

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // A digit above the units is blank when it and every digit above it are zero
  always_comb begin
    w_blank = '0;
    for (int k = 1; k < DIGITS; k++) begin
      w_blank[k] = (BLANK_LZ != 0) && ((r_bcd >> (4 * k)) == '0);
    end
  end

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      seg7_encode u_encode (
        .digit (r_bcd[4*k +: 4]),
        .blank (w_blank[k]),
        .dash  (r_ovf_n),
        .seg   (w_seg_raw[7*k +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf_n <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_seg   <= SEG_INV;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shreg <= bus.bin_in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf_n <= w_ovf_in;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shreg[IN_W-1]};
          r_shreg <= {r_shreg[IN_W-2:0], 1'b0};
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_SHIFT) r_state <= LOAD;
        end
        LOAD: begin
          r_seg   <= w_seg_raw ^ SEG_INV;
          r_ovf   <= r_ovf_n;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.seg      = r_seg;

endmodule
`default_nettype wire
